// File: rtl/adc_frame_reader.sv
// Streams one completed ADC frame from the sample buffer RAM as an AXI4-Stream master.
// Optional build macro ADC_TWOS_COMP_EN: invert the sample MSB (offset-binary to two's complement).
module adc_frame_reader #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 12,
  parameter int FRAME_LEN = 1024
) (
  input  logic              adc_clk,
  input  logic              rst,
  input  logic              frame_done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] FRAME_LEN_C = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LAST_IDX_C  = (ADDR_W+1)'(FRAME_LEN - 1);

  state_t              state_r;
  logic [ADDR_W:0]     issued_r;
  logic [ADDR_W:0]     out_idx_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                pend_r;
  logic [DATA_W-1:0]   fifo_mem_r [2];
  logic                wr_ptr_r;
  logic                rd_ptr_r;
  logic [1:0]          count_r;
  logic                overrun_r;

  logic                pop_s;
  logic                issue_s;
  logic [2:0]          fill_s;

  function automatic logic [DATA_W-1:0] conv_sample(input logic [DATA_W-1:0] d);
`ifdef ADC_TWOS_COMP_EN
    return {~d[DATA_W-1], d[DATA_W-2:0]};
`else
    return d;
`endif
  endfunction

  // Read-issue decision: occupancy after this cycle plus reads still in flight must leave a free slot
  always_comb begin
    pop_s   = 1'b0;
    fill_s  = 3'd0;
    issue_s = 1'b0;
    pop_s   = (count_r != 2'd0) && m_axis_tready;
    fill_s  = {1'b0, count_r} + {2'b00, pend_r} - {2'b00, pop_s};
    if ((state_r == STREAM) && (issued_r < FRAME_LEN_C) && (fill_s < 3'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign buf_rd_en     = issue_s;
  assign buf_rd_addr   = rd_addr_r;
  assign m_axis_tdata  = fifo_mem_r[rd_ptr_r];
  assign m_axis_tvalid = (count_r != 2'd0);
  assign m_axis_tlast  = (count_r != 2'd0) && (out_idx_r == LAST_IDX_C);
  assign busy          = (state_r == STREAM);
  assign overrun       = overrun_r;

  // Frame FSM, read pipeline and 2-entry output FIFO
  always_ff @(posedge adc_clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      issued_r      <= '0;
      out_idx_r     <= '0;
      rd_addr_r     <= '0;
      pend_r        <= 1'b0;
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      overrun_r     <= 1'b0;
    end else begin
      overrun_r <= (state_r == STREAM) && frame_done;
      pend_r    <= issue_s;
      // RAM data returns the cycle after the read; it lands in the FIFO at this edge
      if (pend_r) begin
        fifo_mem_r[wr_ptr_r] <= conv_sample(buf_rd_data);
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_r + {1'b0, pend_r} - {1'b0, pop_s};

      case (state_r)
        IDLE: begin
          issued_r  <= '0;
          out_idx_r <= '0;
          rd_addr_r <= '0;
          if (frame_done) begin
            state_r <= STREAM;
          end
        end
        STREAM: begin
          if (issue_s) begin
            issued_r  <= issued_r + (ADDR_W+1)'(1);
            rd_addr_r <= rd_addr_r + ADDR_W'(1);
          end
          if (pop_s) begin
            out_idx_r <= out_idx_r + (ADDR_W+1)'(1);
            if (out_idx_r == LAST_IDX_C) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// Randomized self-checking bench for adc_frame_reader with a frame-level stream model.
module tb_adc_frame_reader;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 12;
  localparam int FRAME_LEN = 1024;

  logic              adc_clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_done = 1'b0;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data = '0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b0;
  logic              busy;
  logic              overrun;

  adc_frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_LEN(FRAME_LEN)) dut (
    .adc_clk(adc_clk), .rst(rst), .frame_done(frame_done),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .busy(busy), .overrun(overrun)
  );

  always #5 adc_clk = ~adc_clk;

  // Sample buffer RAM with one-cycle synchronous read
  logic [7:0] mem [0:4095];
  always @(posedge adc_clk) begin
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [7:0] d);
`ifdef ADC_TWOS_COMP_EN
    return d ^ 8'h80;
`else
    return d;
`endif
  endfunction

  // Frame-level model state
  int         cyc = 0;
  bit         mdl_busy = 1'b0;
  bit         exp_ovr = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;
  int         rd_next = 0;
  int         beat = 0;
  int         frames = 0;
  int         ovr_cnt = 0;
  int         start_cyc = 0;
  int         first_valid_cyc = 0;
  int         last_hs_cyc = 0;
  logic [7:0] cap [FRAME_LEN];
  int         cap_cyc [FRAME_LEN];

  // Compare process: checks every output mid-cycle against the stream model
  always @(negedge adc_clk) begin
    bit hs;
    bit last_hs;
    cyc++;
    if (rst) begin
      mdl_busy   = 1'b0;
      exp_ovr    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      hs      = m_axis_tvalid && m_axis_tready;
      last_hs = 1'b0;
      check("busy", busy, mdl_busy);
      check("overrun", overrun, exp_ovr);
      if (overrun) ovr_cnt++;
      if (buf_rd_en) begin
        check("rd_in_frame", 1, mdl_busy);
        check("rd_addr", buf_rd_addr, rd_next);
        rd_next++;
      end
      if (prev_stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, prev_data);
        check("hold_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid) begin
        check("valid_in_frame", 1, mdl_busy);
        if (hs && beat < FRAME_LEN) begin
          check("tdata", m_axis_tdata, conv(mem[beat]));
          check("tlast", m_axis_tlast, (beat == FRAME_LEN - 1));
          cap[beat]     = m_axis_tdata;
          cap_cyc[beat] = cyc;
          if (beat == 0) first_valid_cyc = cyc;
          if (beat == FRAME_LEN - 1) begin
            last_hs     = 1'b1;
            last_hs_cyc = cyc;
          end
          beat++;
        end
      end
      if (mdl_busy) check("outstanding", (rd_next - beat) <= 2, 1);
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      exp_ovr    = frame_done && mdl_busy;
      if (mdl_busy && last_hs) begin
        check("reads_per_frame", rd_next, FRAME_LEN);
        mdl_busy = 1'b0;
        frames++;
      end else if (!mdl_busy && frame_done) begin
        mdl_busy  = 1'b1;
        rd_next   = 0;
        beat      = 0;
        start_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic pulse_frame_done();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  task automatic wait_frame(input bit rand_ready, input int bound);
    int f0 = frames;
    int n  = 0;
    while (frames == f0 && n < bound) begin
      m_axis_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      tick();
      n++;
    end
    check("frame_timeout", frames != f0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, buf_rd_en, 0);
    check({tag, "_rd_addr"}, buf_rd_addr, 0);
    check({tag, "_tdata"}, m_axis_tdata, 0);
    check({tag, "_tvalid"}, m_axis_tvalid, 0);
    check({tag, "_tlast"}, m_axis_tlast, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    int s0;
    int o0;
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = i[7:0];
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Ramp frame, tready held high
    m_axis_tready = 1'b1;
    pulse_frame_done();
    wait_frame(1'b0, 2000);
    check("first_valid_latency", first_valid_cyc - start_cyc, 3);
    check("tlast_cycle", last_hs_cyc - start_cyc, 1026);
    check("busy_after_frame", busy, 0);
`ifdef ADC_TWOS_COMP_EN
    check("ramp_last", cap[1023], 8'h7F);
    check("ramp_256", cap[256], 8'h80);
`else
    check("ramp_last", cap[1023], 8'hFF);
    check("ramp_256", cap[256], 8'h00);
`endif

    // Random data, random backpressure
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    pulse_frame_done();
    wait_frame(1'b1, 6000);

    // Long initial stall
    m_axis_tready = 1'b0;
    pulse_frame_done();
    repeat (18) tick();
    #5;
    check("stall_reads", rd_next, 2);
    check("stall_beats", beat, 0);
    tick();
    wait_frame(1'b0, 2000);
    check("stall_release_cycle", cap_cyc[0] - start_cyc, 20);

    // Overrun at beat 500 and at the tlast handshake, back-to-back restart
    m_axis_tready = 1'b1;
    o0 = ovr_cnt;
    frame_done = 1'b1;
    tick();
    s0 = start_cyc;
    for (int c = 1; c <= 1028; c++) begin
      frame_done = (c == 503 || c == 1026 || c == 1027);
      if (c == 1028) check("restart_busy", busy, 1);
      tick();
    end
    frame_done = 1'b0;
    check("restart_start", start_cyc - s0, 1027);
    wait_frame(1'b0, 2000);
    check("overrun_pulses", ovr_cnt - o0, 2);

    // Asynchronous reset mid-frame
    mem[0] = 8'h12;
    pulse_frame_done();
    n = 0;
    while (beat < 300 && n < 2000) begin
      tick();
      n++;
    end
    check("reach_beat_300", beat >= 300, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    tick();
    pulse_frame_done();
    wait_frame(1'b0, 2000);
`ifdef ADC_TWOS_COMP_EN
    check("post_rst_first", cap[0], 8'h92);
`else
    check("post_rst_first", cap[0], 8'h12);
`endif

    // Conversion corner values
    mem[0] = 8'h80;
    mem[1] = 8'h00;
    mem[2] = 8'hFF;
    pulse_frame_done();
    wait_frame(1'b1, 6000);
`ifdef ADC_TWOS_COMP_EN
    check("conv_0", cap[0], 8'h00);
    check("conv_1", cap[1], 8'h80);
    check("conv_2", cap[2], 8'h7F);
`else
    check("conv_0", cap[0], 8'h80);
    check("conv_1", cap[1], 8'h00);
    check("conv_2", cap[2], 8'hFF);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_reader.md
# adc_frame_reader

Reads one completed 1024-sample ADC frame out of the sample buffer RAM, after the ADC sampler signals frame completion, and streams it to downstream consumers (FFT core, waveform display) as an AXI4-Stream master with full backpressure support. It is the read-side partner of the sampler's buffer write port. It shares that port's clock and the RAM's 1-cycle synchronous read latency, and re-arms automatically for the next frame.

## Interface
- DATA_W, 8, sample width; equals the buffer data width.
- ADDR_W, 12, buffer address width.
- FRAME_LEN, 1024, samples per frame; must be ≤ 2^ADDR_W.

Ports:
- adc_clk  in  1  clock; same domain as the sampler and the buffer RAM.
- rst  in  1  reset; asynchronous, active-high.
- frame_done  in  1  one-cycle pulse: frame fully written (sampler last-data flag).
- buf_rd_en  out  1  RAM read enable.
- buf_rd_addr  out  ADDR_W  RAM read address.
- buf_rd_data  in  DATA_W  RAM read data; valid the cycle after buf_rd_en.
- m_axis_tdata  out  DATA_W  stream sample.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  high with sample FRAME_LEN-1.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  frame transfer in progress.
- overrun  out  1  one-cycle pulse: frame_done arrived while not IDLE.

## Operation
- States: IDLE, STREAM.
- IDLE:
  - frame_done=1 → STREAM.
  - rd_addr cleared to 0.
  - Read-issue count cleared to 0.
- STREAM:
  - Issues reads for addresses 0..FRAME_LEN-1 in order, each exactly once.
  - Read data enters a 2-entry output FIFO. The FIFO head drives the m_axis_* outputs.
  - Read issue condition: issued < FRAME_LEN and (fifo_occupancy + reads_in_flight − pop_this_cycle) < 2. This guarantees returning RAM data never overflows the FIFO.
  - pop = m_axis_tvalid & m_axis_tready.
  - m_axis_tlast = 1 iff the head entry is sample FRAME_LEN-1, tracked by an output index counter of ADDR_W+1 bits.
  - STREAM → IDLE on the handshake of the tlast sample.
- busy = (state == STREAM).
- frame_done while in STREAM, including the final-handshake cycle, is ignored and pulses overrun for one cycle. The current frame continues unaffected.
- AXI rules:
  - tdata and tlast are held stable while tvalid=1 and tready=0.
  - tvalid never drops without a handshake.
  - tvalid does not depend combinationally on tready.
- Counters: issue and output counters are ADDR_W+1 bits wide so the FRAME_LEN=2^ADDR_W case cannot wrap.
- Reset (async, any time):
  - state=IDLE, FIFO emptied, counters cleared.
  - All outputs 0: buf_rd_en, buf_rd_addr, m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, overrun.
  - Reset mid-frame abandons the frame; the next frame_done after release starts a new frame at address 0.

## Timing
- frame_done high in cycle 0.
- Cycle 1: busy=1, buf_rd_en=1, buf_rd_addr=0.
- Cycle 2: buf_rd_data valid.
- Cycle 3: m_axis_tvalid=1 with sample 0.
- With tready held 1: sample k is presented in cycle 3+k, and tlast accompanies sample 1023 in cycle 1026.
  - busy=0 from cycle 1027.
  - Sustained throughput is 1 sample/cycle.
- tready low: read issue stalls within one cycle and at most 2 samples are buffered. Output resumes in the same cycle tready returns high.
- Minimum turnaround: a frame_done in the cycle after the final handshake is accepted.
- overrun is registered and asserts the cycle after the offending frame_done.

## Configuration
- ADC_TWOS_COMP_EN defined: m_axis_tdata = buffer data with the MSB inverted. This converts AD9280 offset-binary to two's complement, so 0x80 → 0x00 and 0x00 → 0x80.
- ADC_TWOS_COMP_EN undefined: m_axis_tdata = buffer data unchanged.
- Conversion is applied on FIFO write. Latency is identical in both builds.

## Test plan
- RAM preloaded with mem[i]=i[7:0]; frame_done pulse; tready=1 → 1024 beats with data 0x00..0xFF repeating, tlast only on beat 1023 (data 0xFF), first tvalid 3 cycles after frame_done, busy low in cycle 1027.
- Same frame with tready toggling pseudo-randomly (≈50%) → identical data sequence, no duplicates or drops, tdata/tlast stable across every stalled cycle, buf_rd_addr never skips or repeats.
- tready=0 from cycle 0 for 20 cycles, then 1 → exactly 2 reads issued before the stall, then sample 0 delivered the cycle tready rises.
- frame_done re-pulsed at beat 500 and at the tlast handshake cycle → overrun pulses once for each, frame completes unchanged; a frame_done one cycle after the tlast handshake starts a new frame at address 0.
- rst asserted at beat 300 for 2 cycles → all outputs 0 asynchronously; next frame_done streams from sample 0.
- Build with ADC_TWOS_COMP_EN, mem[0]=0x80, mem[1]=0x00, mem[2]=0xFF → beats 0x00, 0x80, 0x7F.
